// File: rtl/smvm_issue_ctrl.sv
// Front-end issue controller for the K-lane SpMV datapath: parses the input
// stream, stores the dense vector and packs nonzeros into K-lane issue words.
module smvm_issue_ctrl #(
  parameter int unsigned K      = 4,
  parameter int unsigned VDEPTH = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_type,
  input  logic [7:0]     in_data,
  input  logic [6:0]     in_col,
  input  logic           in_eor,
  output logic           iss_valid,
  input  logic           iss_ready,
  output logic [8*K-1:0] iss_val,
  output logic [8*K-1:0] iss_vec,
  output logic [K-1:0]   iss_ipv,
  output logic [K-1:0]   iss_lane_en,
  input  logic           res_valid,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = $clog2(VDEPTH);
  localparam int unsigned LW = (K > 1) ? $clog2(K) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(K - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VEC   = 2'd1;
  localparam logic [1:0] S_NZ    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] T_HDR = 2'd0;
  localparam logic [1:0] T_VEC = 2'd1;
  localparam logic [1:0] T_NZ  = 2'd2;
  localparam logic [1:0] T_END = 2'd3;

  logic [1:0]           state, state_nxt;
  logic                 alive_q;
  logic [DW-1:0]        rows, cols, vec_cnt, eor_cnt, res_cnt;
  logic [LW-1:0]        lane_cnt, lane_idx;
  logic [K-1:0][DW-1:0] acc_val, acc_vec, w_val, w_vec;
  logic [K-1:0]         acc_ipv, w_ipv, w_en;
  logic [DW-1:0]        vec_mem [VDEPTH];
  logic [DW-1:0]        operand;
  logic                 col_ok, out_free, beat;
  logic                 hdr_ld, vec_wr, nz_acc, word_full, flush, err_nxt, done_nxt;

  assign out_free  = !iss_valid || iss_ready;
  assign col_ok    = DW'(in_col) < cols;
  assign operand   = col_ok ? vec_mem[AW'(in_col)] : '0;
  assign lane_idx  = LANE_LAST - lane_cnt;
  assign word_full = nz_acc && (lane_cnt == LANE_LAST);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, beat acceptance and per-beat actions
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    beat      = 1'b0;
    hdr_ld    = 1'b0;
    vec_wr    = 1'b0;
    nz_acc    = 1'b0;
    flush     = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = alive_q;
        beat     = in_valid && in_ready;
        if (beat) begin
          if (in_type == T_HDR && in_data != '0) begin
            hdr_ld    = 1'b1;
            state_nxt = S_VEC;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_VEC: begin
        in_ready = 1'b1;
        beat     = in_valid;
        if (beat) begin
          if (in_type == T_VEC) begin
            vec_wr = 1'b1;
            if (vec_cnt == cols - DW'(1)) state_nxt = S_NZ;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_NZ: begin
        if (in_type == T_NZ)       in_ready = (lane_cnt != LANE_LAST) || out_free;
        else if (in_type == T_END) in_ready = out_free;
        else                       in_ready = 1'b1;
        beat = in_valid && in_ready;
        if (beat) begin
          if (in_type == T_NZ) begin
            nz_acc  = 1'b1;
            err_nxt = !col_ok;
          end else if (in_type == T_END) begin
            flush     = (lane_cnt != '0);
            state_nxt = S_DRAIN;
            err_nxt   = (eor_cnt != rows);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (!iss_valid && res_cnt == rows) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Candidate issue word: accumulated lanes plus the lane filled this cycle
  always_comb begin
    w_val = acc_val;
    w_vec = acc_vec;
    w_ipv = acc_ipv;
    w_en  = '0;
    if (nz_acc) begin
      w_val[lane_idx] = in_data;
      w_vec[lane_idx] = operand;
      w_ipv[lane_idx] = in_eor;
    end
    for (int i = 0; i < K; i++) begin
      w_en[K-1-i] = word_full || (LW'(i) < lane_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q     <= 1'b0;
      rows        <= '0;
      cols        <= '0;
      vec_cnt     <= '0;
      eor_cnt     <= '0;
      res_cnt     <= '0;
      lane_cnt    <= '0;
      acc_val     <= '0;
      acc_vec     <= '0;
      acc_ipv     <= '0;
      iss_valid   <= 1'b0;
      iss_val     <= '0;
      iss_vec     <= '0;
      iss_ipv     <= '0;
      iss_lane_en <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      err     <= err_nxt;
      done    <= done_nxt;
      if (hdr_ld) begin
        rows     <= in_data;
        cols     <= DW'(in_col) + DW'(1);
        vec_cnt  <= '0;
        eor_cnt  <= '0;
        res_cnt  <= '0;
        lane_cnt <= '0;
        acc_val  <= '0;
        acc_vec  <= '0;
        acc_ipv  <= '0;
      end
      if (vec_wr) vec_cnt <= vec_cnt + DW'(1);
      if (nz_acc) begin
        lane_cnt <= lane_cnt + LW'(1);
        if (in_eor) eor_cnt <= eor_cnt + DW'(1);
      end
      // A completed or flushed word always lands in the issue register
      if (word_full || flush) begin
        lane_cnt    <= '0;
        acc_val     <= '0;
        acc_vec     <= '0;
        acc_ipv     <= '0;
        iss_valid   <= 1'b1;
        iss_val     <= w_val;
        iss_vec     <= w_vec;
        iss_ipv     <= w_ipv;
        iss_lane_en <= w_en;
      end else begin
        if (nz_acc) begin
          acc_val <= w_val;
          acc_vec <= w_vec;
          acc_ipv <= w_ipv;
        end
        if (iss_ready) begin
          iss_valid   <= 1'b0;
          iss_val     <= '0;
          iss_vec     <= '0;
          iss_ipv     <= '0;
          iss_lane_en <= '0;
        end
      end
      if (res_valid && state != S_IDLE && res_cnt != rows) res_cnt <= res_cnt + DW'(1);
    end
  end

  // Dense vector storage, deliberately left uninitialised across reset
  always_ff @(posedge clk) begin
    if (vec_wr) vec_mem[AW'(vec_cnt)] <= in_data;
  end

endmodule

// File: doc/smvm_issue_ctrl.md
# smvm_issue_ctrl

Front-end scheduler for the k-lane sparse matrix–vector multiply datapath. It parses the serial input stream (header, dense vector, nonzero stream), stores the dense vector, and packs nonzeros into K-lane issue words of matrix value, gathered vector operand and row-end bit. It issues these words to the L1 ALU/map-table pipeline over a valid/ready handshake, then tracks per-row results to report job completion.

## Interface
- K, 4, lanes per issue word
- VDEPTH, 128, vector memory entries (max cols)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_type  in  2  00 header, 01 vector element, 10 nonzero, 11 end-of-matrix
- in_data  in  8  header: rows; vector: signed element; nonzero: signed value
- in_col  in  7  header: cols-1; nonzero: column index
- in_eor  in  1  nonzero is last of its row
- iss_valid  out  1  issue word valid
- iss_ready  in  1  datapath accepts word
- iss_val  out  8K  lane values, lane 0 in bits [8K-1 -: 8]
- iss_vec  out  8K  gathered vector operands, same lane order
- iss_ipv  out  K  row-end bits, lane 0 = bit K-1
- iss_lane_en  out  K  filled lanes, lane 0 = bit K-1
- res_valid  in  1  one pulse per row result leaving the output stage
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, job complete
- err  out  1  one-cycle pulse, protocol error

## Operation
- States: IDLE, VEC, NZ, DRAIN.
- IDLE: in_ready=1. Header with rows>0 latches rows and cols=in_col+1, clears counters, goes to VEC. Any other beat, or rows=0: err, beat dropped, stay IDLE.
- VEC: in_ready=1. Element n is written to vec[n], n=0..cols-1. The cols-th element moves the FSM to NZ. A non-vector beat: err, dropped.
- NZ: each nonzero fills lane lane_cnt with {value, vec[in_col] (combinational read), in_eor}.
  - in_col ≥ cols: err; operand forced to 0; beat still consumed.
  - lane_cnt wraps at K-1.
  - Filling lane K-1 loads the word directly into the issue register.
- out_free = !iss_valid || iss_ready.
  - In NZ, in_ready = (lane_cnt != K-1) || out_free for nonzeros, and in_ready = out_free for end beats.
- End beat in NZ:
  - Flushes a partial word if lane_cnt>0: unfilled lanes have val/vec/ipv=0 and lane_en=0.
  - Then goes to DRAIN.
  - If the total eor count ≠ rows: err.
  - Header/vector beats in NZ: err, dropped.
- DRAIN: in_ready=0. When iss_valid=0 and res_cnt==rows, pulse done and go to IDLE.
- res_cnt (8-bit) increments on res_valid in any non-IDLE state and saturates at rows.
- Empty rows are not supported: every row has ≥1 nonzero.

## Timing
- Reset values: in_ready=0 during reset, then 1 (IDLE). iss_valid=0, iss_* all 0, busy=0, done=0, err=0. Vector memory is not cleared.
- Issue latency: a word is visible on iss_* the cycle after the beat that completes it.
- iss_* are held stable while iss_valid && !iss_ready. If iss_ready and a new word completes in the same cycle, the new word replaces the old with no bubble.
- Throughput: 1 nonzero per cycle with iss_ready held high.
- err and done are registered and asserted one cycle after the causing event.
- rst_n mid-job: immediate return to IDLE; the in-flight word is discarded.

## Test plan
- Header rows=2, cols=4; vector [1,2,3,4]; nonzeros (5,c0),(6,c2,eor),(7,c1),(8,c3,eor); end; two res_valid pulses -> one word: val {5,6,7,8}, vec {1,3,2,4}, ipv 0101, lane_en 1111; done pulses once after the 2nd res_valid.
- Same job but 6 nonzeros -> second word has lane_en 1100, lanes 2–3 zero.
- iss_ready low for 5 cycles with a full word pending and lane_cnt=3 -> in_ready=0; iss_* stable; no beat lost; resumes once iss_ready=1.
- Nonzero with in_col=9, cols=4 -> err pulse; lane operand 0; word still issues.
- Vector beat in IDLE, or header with rows=0 -> err; busy stays 0.
- Assert rst_n low in NZ with iss_valid=1 -> all outputs return to reset values; a new job then runs correctly.
